// File: rtl/mac_pipe_if.sv
// mac_pipe_if: stream bus for the mac_pipe datapath.
//
// Upstream side : in_valid, in_ready, ina, inb, inc
// Downstream side: out_valid, out_ready, out, out_ovf
//
// Modports:
//   master - the producer/consumer environment around the pipe
//   slave  - the mac_pipe block itself
interface mac_pipe_if #(
  parameter int W     = 3,
  parameter int OUT_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     ina;
  logic [W-1:0]     inb;
  logic [W-1:0]     inc;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out;
  logic             out_ovf;

  modport master (
    output in_valid, ina, inb, inc, out_ready,
    input  in_ready, out_valid, out, out_ovf
  );

  modport slave (
    input  in_valid, ina, inb, inc, out_ready,
    output in_ready, out_valid, out, out_ovf
  );
endinterface

// File: rtl/mac_pipe.sv
// mac_pipe: three-stage streaming datapath computing
//   out = (ina + inb) * inc + inc
// for every accepted beat, with valid/ready flow control and per-stage
// bubble collapse. Each beat carries its own inc down the pipe.
//
// Ports:
//   clk  - sole clock, rising edge
//   rst  - asynchronous active-low reset; clears all state immediately
//   bus  - mac_pipe_if.slave: in_valid/in_ready/ina/inb/inc upstream,
//          out_valid/out_ready/out/out_ovf downstream (outputs registered)
//
// Parameters:
//   W     - operand width (>= 1)
//   OUT_W - result width (1 .. 2W+2)
//
// Build option:
//   MAC_PIPE_SATURATE_EN - when defined, an overflowing result is clamped
//                          to all ones instead of wrapping. out_ovf is the
//                          same in both builds.
module mac_pipe #(
  parameter int W     = 3,
  parameter int OUT_W = 6
) (
  input  logic      clk,
  input  logic      rst,
  mac_pipe_if.slave bus
);

  localparam int SUM_W  = W + 1;
  localparam int PROD_W = 2 * W + 1;
  localparam int FULL_W = 2 * W + 2;

  // True when any bit at or above OUT_W is set in the full-precision result.
  function automatic logic ovf_of(input logic [FULL_W-1:0] full);
    logic [FULL_W-1:0] hi;
    hi = full >> OUT_W;
    return |hi;
  endfunction

  // Stage valid bits
  logic v1_q, v1_d;
  logic v2_q, v2_d;
  logic v3_q, v3_d;

  // Stage data registers
  logic [SUM_W-1:0]  sum_q,  sum_d;
  logic [W-1:0]      c1_q,   c1_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [W-1:0]      c2_q,   c2_d;
  logic [OUT_W-1:0]  out_q,  out_d;
  logic              ovf_q,  ovf_d;

  // Advance enables and S3 arithmetic
  logic              adv1_s, adv2_s, adv3_s;
  logic [FULL_W-1:0] full_s;
  logic              ovf_s;

  // Advance chain: a stage moves when it is empty or its successor moves,
  // so an empty stage always fills even while the output is stalled.
  always_comb begin
    adv3_s = !v3_q || bus.out_ready;
    adv2_s = !v2_q || adv3_s;
    adv1_s = !v1_q || adv2_s;
  end

  // Full-precision final add and overflow detection feeding the output register.
  always_comb begin
    full_s = FULL_W'(prod_q) + FULL_W'(c2_q);
    ovf_s  = ovf_of(full_s);
  end

  // Next-state for every stage; non-advancing stages hold.
  always_comb begin
    v1_d   = v1_q;
    v2_d   = v2_q;
    v3_d   = v3_q;
    sum_d  = sum_q;
    c1_d   = c1_q;
    prod_d = prod_q;
    c2_d   = c2_q;
    out_d  = out_q;
    ovf_d  = ovf_q;

    if (adv1_s) begin
      v1_d  = bus.in_valid;
      sum_d = SUM_W'(bus.ina) + SUM_W'(bus.inb);
      c1_d  = bus.inc;
    end else begin
      v1_d  = v1_q;
      sum_d = sum_q;
      c1_d  = c1_q;
    end

    if (adv2_s) begin
      v2_d   = v1_q;
      prod_d = PROD_W'(sum_q) * PROD_W'(c1_q);
      c2_d   = c1_q;
    end else begin
      v2_d   = v2_q;
      prod_d = prod_q;
      c2_d   = c2_q;
    end

    if (adv3_s) begin
      v3_d  = v2_q;
      ovf_d = ovf_s;
`ifdef MAC_PIPE_SATURATE_EN
      if (ovf_s) begin
        out_d = {OUT_W{1'b1}};
      end else begin
        out_d = full_s[OUT_W-1:0];
      end
`else
      out_d = full_s[OUT_W-1:0];
`endif
    end else begin
      v3_d  = v3_q;
      out_d = out_q;
      ovf_d = ovf_q;
    end
  end

  // Pipeline state register; reset discards all in-flight beats at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      sum_q  <= {SUM_W{1'b0}};
      c1_q   <= {W{1'b0}};
      prod_q <= {PROD_W{1'b0}};
      c2_q   <= {W{1'b0}};
      out_q  <= {OUT_W{1'b0}};
      ovf_q  <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      sum_q  <= sum_d;
      c1_q   <= c1_d;
      prod_q <= prod_d;
      c2_q   <= c2_d;
      out_q  <= out_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.in_ready  = adv1_s;
  assign bus.out_valid = v3_q;
  assign bus.out       = out_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_pipe.sv
// tb_mac_pipe: self-checking bench for mac_pipe (W=3, OUT_W=6).
// Expected results come from a reference model pushed onto a queue at
// accept time and popped when the DUT delivers a result.
module tb_mac_pipe;
  localparam int W     = 3;
  localparam int OUT_W = 6;
`ifdef MAC_PIPE_SATURATE_EN
  localparam logic [OUT_W-1:0] OVF_OUT = 6'd63;
`else
  localparam logic [OUT_W-1:0] OVF_OUT = 6'd41;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic [OUT_W:0] exp_q[$];

  mac_pipe_if #(.W(W), .OUT_W(OUT_W)) bus ();
  mac_pipe #(.W(W), .OUT_W(OUT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, out} for one beat.
  function automatic logic [OUT_W:0] model(input int a, input int b, input int c);
    logic [31:0] full;
    logic [31:0] o;
    logic        ovf;
    full = 32'((a + b) * c + c);
    ovf  = (full >= (32'd1 << OUT_W));
    o    = full % (32'd1 << OUT_W);
`ifdef MAC_PIPE_SATURATE_EN
    if (ovf) o = (32'd1 << OUT_W) - 32'd1;
`endif
    return {ovf, o[OUT_W-1:0]};
  endfunction

  task automatic drive(input logic v, input int a, input int b, input int c);
    bus.in_valid = v;
    bus.ina      = W'(a);
    bus.inb      = W'(b);
    bus.inc      = W'(c);
  endtask

  // Called at a falling edge: samples handshake state 1 unit before the
  // next rising edge, then returns at the following falling edge.
  task automatic tick(output logic acc, output logic dlv, output logic vld,
                      output logic [OUT_W-1:0] o, output logic ovf);
    #4;
    acc = bus.in_valid & bus.in_ready;
    vld = bus.out_valid;
    dlv = bus.out_valid & bus.out_ready;
    o   = bus.out;
    ovf = bus.out_ovf;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 0, 0, 0);
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out !== 6'd0) $display("FAIL rst_out: got %0d want 0", bus.out); else n_pass++;
    n_checks++; if (bus.out_ovf !== 1'b0) $display("FAIL rst_ovf: got %b want 0", bus.out_ovf); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rel_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    @(negedge clk);
  endtask

  // One isolated beat: latency 3 and a known result.
  task automatic test_single(input string name, input int a, input int b, input int c,
                             input logic [OUT_W-1:0] want_o, input logic want_ovf);
    logic acc, dlv, vld, ovf;
    logic [OUT_W-1:0] o;
    logic [OUT_W-1:0] got_o;
    logic got_ovf;
    int lat;
    bus.out_ready = 1'b1;
    drive(1'b1, a, b, c);
    tick(acc, dlv, vld, o, ovf);
    drive(1'b0, 0, 0, 0);
    n_checks++; if (acc !== 1'b1) $display("FAIL %s_accept: got %b want 1", name, acc); else n_pass++;
    lat = -1; got_o = '0; got_ovf = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick(acc, dlv, vld, o, ovf);
      if (dlv && lat < 0) begin
        lat = i; got_o = o; got_ovf = ovf;
      end
    end
    n_checks++; if (lat !== 3) $display("FAIL %s_latency: got %0d want 3", name, lat); else n_pass++;
    n_checks++; if (got_o !== want_o) $display("FAIL %s_out: got %0d want %0d", name, got_o, want_o); else n_pass++;
    n_checks++; if (got_ovf !== want_ovf) $display("FAIL %s_ovf: got %b want %b", name, got_ovf, want_ovf); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int va[4] = '{0, 1, 2, 7};
    int vb[4] = '{0, 1, 3, 0};
    int vc[4] = '{0, 1, 4, 1};
    logic acc, dlv, vld, ovf;
    logic [OUT_W-1:0] o;
    logic [OUT_W:0] e;
    int idx, ndlv, last_t;
    idx = 0; ndlv = 0; last_t = -1;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      if (idx < 4) drive(1'b1, va[idx], vb[idx], vc[idx]);
      else drive(1'b0, 0, 0, 0);
      tick(acc, dlv, vld, o, ovf);
      if (acc) begin
        exp_q.push_back(model(va[idx], vb[idx], vc[idx]));
        idx++;
      end
      if (dlv) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL b2b_extra: got out=%0d with nothing expected", o);
        else begin
          e = exp_q.pop_front();
          if ({ovf, o} !== e) $display("FAIL b2b_data: got out=%0d ovf=%b want out=%0d ovf=%b", o, ovf, e[OUT_W-1:0], e[OUT_W]);
          else n_pass++;
        end
        n_checks++;
        if (ndlv == 0) begin
          if (t !== 3) $display("FAIL b2b_first: got cycle %0d want 3", t); else n_pass++;
        end else begin
          if (t !== last_t + 1) $display("FAIL b2b_gap: got cycle %0d want %0d", t, last_t + 1); else n_pass++;
        end
        last_t = t;
        ndlv++;
      end
    end
    n_checks++; if (ndlv !== 4) $display("FAIL b2b_count: got %0d want 4", ndlv); else n_pass++;
  endtask

  task automatic test_stall();
    int va[5] = '{1, 7, 3, 2, 6};
    int vb[5] = '{2, 7, 0, 2, 1};
    int vc[5] = '{3, 7, 5, 1, 2};
    logic acc, dlv, vld, ovf;
    logic [OUT_W-1:0] o;
    logic [OUT_W-1:0] hold_o;
    logic hold_ovf;
    logic [OUT_W:0] e;
    int idx, ndlv;
    idx = 0; ndlv = 0; hold_o = '0; hold_ovf = 1'b0;
    for (int t = 0; t < 30; t++) begin
      bus.out_ready = (t >= 5);
      if (idx < 5) drive(1'b1, va[idx], vb[idx], vc[idx]);
      else drive(1'b0, 0, 0, 0);
      tick(acc, dlv, vld, o, ovf);
      if (t == 3 || t == 4) begin
        n_checks++; if (acc !== 1'b0) $display("FAIL stall_in_ready: cycle %0d accepted=%b want 0", t, acc); else n_pass++;
      end
      if (t == 3) begin
        n_checks++; if (vld !== 1'b1) $display("FAIL stall_valid: got %b want 1", vld); else n_pass++;
        hold_o = o; hold_ovf = ovf;
      end
      if (t == 4 || t == 5) begin
        n_checks++; if ({ovf, o} !== {hold_ovf, hold_o}) $display("FAIL stall_stable: got %0d/%b want %0d/%b", o, ovf, hold_o, hold_ovf); else n_pass++;
      end
      if (t == 4) begin
        n_checks++; if (idx !== 3) $display("FAIL stall_accepts: got %0d want 3", idx); else n_pass++;
      end
      if (acc) begin
        exp_q.push_back(model(va[idx], vb[idx], vc[idx]));
        idx++;
      end
      if (dlv) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL stall_extra: got out=%0d with nothing expected", o);
        else begin
          e = exp_q.pop_front();
          if ({ovf, o} !== e) $display("FAIL stall_data: got out=%0d ovf=%b want out=%0d ovf=%b", o, ovf, e[OUT_W-1:0], e[OUT_W]);
          else n_pass++;
        end
        ndlv++;
      end
    end
    n_checks++; if (ndlv !== 5) $display("FAIL stall_count: got %0d want 5", ndlv); else n_pass++;
  endtask

  task automatic test_bubble();
    int va[6] = '{5, 0, 7, 3, 1, 4};
    int vb[6] = '{2, 6, 1, 3, 1, 4};
    int vc[6] = '{1, 7, 6, 2, 0, 3};
    logic acc, dlv, vld, ovf;
    logic [OUT_W-1:0] o;
    logic [OUT_W:0] e;
    int idx, ndlv;
    idx = 0; ndlv = 0;
    for (int t = 0; t < 30; t++) begin
      bus.out_ready = (t % 2 == 0);
      if (idx < 6 && t != 3) drive(1'b1, va[idx], vb[idx], vc[idx]);
      else drive(1'b0, 0, 0, 0);
      tick(acc, dlv, vld, o, ovf);
      if (acc) begin
        exp_q.push_back(model(va[idx], vb[idx], vc[idx]));
        idx++;
      end
      if (dlv) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL bubble_extra: got out=%0d with nothing expected", o);
        else begin
          e = exp_q.pop_front();
          if ({ovf, o} !== e) $display("FAIL bubble_data: got out=%0d ovf=%b want out=%0d ovf=%b", o, ovf, e[OUT_W-1:0], e[OUT_W]);
          else n_pass++;
        end
        ndlv++;
      end
    end
    n_checks++; if (ndlv !== 6) $display("FAIL bubble_count: got %0d want 6", ndlv); else n_pass++;
  endtask

  task automatic test_reset_inflight();
    int va[3] = '{7, 1, 3};
    int vb[3] = '{7, 2, 3};
    int vc[3] = '{7, 3, 3};
    logic acc, dlv, vld, ovf;
    logic [OUT_W-1:0] o;
    logic [OUT_W-1:0] got_o;
    int lat;
    bus.out_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      drive(1'b1, va[t], vb[t], vc[t]);
      tick(acc, dlv, vld, o, ovf);
    end
    drive(1'b0, 0, 0, 0);
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL rstfly_pre_valid: got %b want 1", bus.out_valid); else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rstfly_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out !== 6'd0) $display("FAIL rstfly_out: got %0d want 0", bus.out); else n_pass++;
    n_checks++; if (bus.out_ovf !== 1'b0) $display("FAIL rstfly_ovf: got %b want 0", bus.out_ovf); else n_pass++;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rstfly_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    @(negedge clk);
    drive(1'b1, 2, 2, 2);
    tick(acc, dlv, vld, o, ovf);
    drive(1'b0, 0, 0, 0);
    lat = -1; got_o = '0;
    for (int i = 1; i <= 8; i++) begin
      tick(acc, dlv, vld, o, ovf);
      if (dlv && lat < 0) begin
        lat = i; got_o = o;
      end
    end
    n_checks++; if (lat !== 3) $display("FAIL rstfly_latency: got %0d want 3", lat); else n_pass++;
    n_checks++; if (got_o !== 6'd10) $display("FAIL rstfly_out_new: got %0d want 10", got_o); else n_pass++;
  endtask

  task automatic test_random();
    logic acc, dlv, vld, ovf;
    logic [OUT_W-1:0] o;
    logic [OUT_W:0] e;
    int a, b, c;
    for (int t = 0; t < 80; t++) begin
      a = int'($urandom_range(7, 0));
      b = int'($urandom_range(7, 0));
      c = int'($urandom_range(7, 0));
      bus.out_ready = (t >= 60) ? 1'b1 : 1'($urandom_range(1, 0));
      drive((t < 60) ? 1'($urandom_range(1, 0)) : 1'b0, a, b, c);
      tick(acc, dlv, vld, o, ovf);
      if (acc) exp_q.push_back(model(a, b, c));
      if (dlv) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL rand_extra: got out=%0d with nothing expected", o);
        else begin
          e = exp_q.pop_front();
          if ({ovf, o} !== e) $display("FAIL rand_data: got out=%0d ovf=%b want out=%0d ovf=%b", o, ovf, e[OUT_W-1:0], e[OUT_W]);
          else n_pass++;
        end
      end
    end
    n_checks++; if (exp_q.size() !== 0) $display("FAIL rand_drain: %0d results missing, want 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_single("basic", 1, 2, 3, 6'd12, 1'b0);
    test_single("ovf", 7, 7, 7, OVF_OUT, 1'b1);
    test_back_to_back();
    test_stall();
    test_bubble();
    test_reset_inflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
